// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline types and constants: PC width, bubble encoding,
// reset PC default and the IF/ID payload struct reused by decode.
package mips_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [PC_W-1:0]    RESET_PC  = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc_plus4;
        logic               valid;
        logic               fault;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and IF/ID outputs.
interface fetch_stage_if #(
    parameter int unsigned IMEM_AW = 8
);
    import mips_pkg::*;

    logic                stall;
    logic                flush;
    logic                redirect_valid;
    logic [PC_W-1:0]     redirect_pc;
    logic [IMEM_AW-1:0]  imem_addr;
    logic [INSTR_W-1:0]  imem_data;
    logic [INSTR_W-1:0]  if_id_instr;
    logic [PC_W-1:0]     if_id_pc;
    logic [PC_W-1:0]     if_id_pc_plus4;
    logic                if_id_valid;
    logic                if_id_fault;

    modport master (
        input  stall, flush, redirect_valid, redirect_pc, imem_data,
        output imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, if_id_fault
    );

    modport slave (
        output stall, flush, redirect_valid, redirect_pc, imem_data,
        input  imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, if_id_fault
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold (stall) and bubble-load (flush/redirect) controls.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   hold,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    // Bubble keeps the pc fields of the squashed slot for exception/debug visibility.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0, fault: 1'b0};
        end else if (bubble) begin
            q <= '{instr: NOP_INSTR, pc: d.pc, pc_plus4: d.pc_plus4, valid: 1'b0, fault: 1'b0};
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS32 instruction-fetch stage: PC, next-PC selection and IF/ID capture.
// Optional FETCH_PERF_CNT_EN adds fetch_count / bubble_count outputs.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = mips_pkg::RESET_PC,
    parameter int unsigned        IMEM_AW   = 8,
    parameter logic [INSTR_W-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_stage_if.master        bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          fetch_count,
    output logic [31:0]          bubble_count
`endif
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus4_c;
    logic [PC_W-1:0] pc_next_c;
    logic            out_of_range_c;
    logic            bubble_c;
    if_id_t          fetch_c;
    if_id_t          if_id_q;

    assign pc_plus4_c     = pc + PC_W'(4);
    assign out_of_range_c = |pc[PC_W-1:IMEM_AW+2];
    assign bubble_c       = bus.redirect_valid | bus.flush;
    assign bus.imem_addr  = pc[IMEM_AW+1:2];

    // Redirect beats stall; redirect target is forced word-aligned.
    always_comb begin
        pc_next_c = pc_plus4_c;
        if (bus.redirect_valid) begin
            pc_next_c = bus.redirect_pc & ~PC_W'(3);
        end else if (bus.stall) begin
            pc_next_c = pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next_c;
        end
    end

    always_comb begin
        fetch_c          = '0;
        fetch_c.instr    = out_of_range_c ? NOP_INSTR : bus.imem_data;
        fetch_c.pc       = pc;
        fetch_c.pc_plus4 = pc_plus4_c;
        fetch_c.valid    = 1'b1;
        fetch_c.fault    = out_of_range_c;
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk    (clk),
        .reset  (reset),
        .hold   (bus.stall),
        .bubble (bubble_c),
        .d      (fetch_c),
        .q      (if_id_q)
    );

    assign bus.if_id_instr    = if_id_q.instr;
    assign bus.if_id_pc       = if_id_q.pc;
    assign bus.if_id_pc_plus4 = if_id_q.pc_plus4;
    assign bus.if_id_valid    = if_id_q.valid;
    assign bus.if_id_fault    = if_id_q.fault;

`ifdef FETCH_PERF_CNT_EN
    // Counts mirror the IF/ID load decision: bubble, real load, or hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else if (bubble_c) begin
            bubble_count <= bubble_count + 32'd1;
        end else if (!bus.stall) begin
            fetch_count  <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus hand-written corner sequences.
module tb_fetch_stage;

    localparam int unsigned AW = 8;

    logic clk;
    logic reset;
    logic [31:0] mem [256];

    int errors;
    int checks;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    fetch_stage_if #(.IMEM_AW(AW)) bus ();

    assign bus.imem_data = mem[bus.imem_addr];

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_AW   (AW),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count  (fetch_count),
        .bubble_count (bubble_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        rv;
        logic [31:0] rp;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_ifpc;
        logic        e_v;
        logic        e_f;
    } vec_t;

    localparam int NV = 24;
    vec_t vt [NV];

    function automatic logic [31:0] mw(input int k);
        return 32'hC0DE_0000 | 32'(k);
    endfunction

    function automatic vec_t mk(input logic rst, input logic st, input logic fl, input logic rv,
                                input logic [31:0] rp, input logic [31:0] e_pc,
                                input logic [31:0] e_instr, input logic [31:0] e_ifpc,
                                input logic e_v, input logic e_f);
        vec_t v;
        v.rst = rst; v.stall = st; v.flush = fl; v.rv = rv; v.rp = rp;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_ifpc = e_ifpc; v.e_v = e_v; v.e_f = e_f;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic st, input logic fl, input logic rv, input logic [31:0] rp);
        reset              = rst;
        bus.stall          = st;
        bus.flush          = fl;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_state(input int idx, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_ifpc, input logic [31:0] e_pp4,
                             input logic e_v, input logic e_f);
        chk("imem_addr", idx, 32'(bus.imem_addr), 32'(e_pc[AW+1:2]));
        chk("if_id_instr", idx, bus.if_id_instr, e_instr);
        chk("if_id_pc", idx, bus.if_id_pc, e_ifpc);
        chk("if_id_pc_plus4", idx, bus.if_id_pc_plus4, e_pp4);
        chk("if_id_valid", idx, 32'(bus.if_id_valid), 32'(e_v));
        chk("if_id_fault", idx, 32'(bus.if_id_fault), 32'(e_f));
    endtask

    initial begin
        logic [31:0] pc_m;
        logic [31:0] nop;

        errors = 0;
        checks = 0;
        nop    = 32'h0000_0000;
        for (int i = 0; i < 256; i++) mem[i] = mw(i);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Expected values are the state right after the edge that applies each row.
        vt[0]  = mk(1, 0, 0, 0, 32'h0,        32'h000,      nop,      32'h000,      0, 0);
        vt[1]  = mk(0, 0, 0, 0, 32'h0,        32'h004,      mw(0),    32'h000,      1, 0);
        vt[2]  = mk(0, 0, 0, 0, 32'h0,        32'h008,      mw(1),    32'h004,      1, 0);
        vt[3]  = mk(0, 1, 0, 0, 32'h0,        32'h008,      mw(1),    32'h004,      1, 0);
        vt[4]  = mk(0, 1, 0, 0, 32'h0,        32'h008,      mw(1),    32'h004,      1, 0);
        vt[5]  = mk(0, 1, 0, 0, 32'h0,        32'h008,      mw(1),    32'h004,      1, 0);
        vt[6]  = mk(0, 0, 0, 0, 32'h0,        32'h00C,      mw(2),    32'h008,      1, 0);
        vt[7]  = mk(0, 0, 0, 0, 32'h0,        32'h010,      mw(3),    32'h00C,      1, 0);
        vt[8]  = mk(0, 1, 0, 1, 32'h23,       32'h020,      nop,      32'h010,      0, 0);
        vt[9]  = mk(0, 0, 0, 0, 32'h0,        32'h024,      mw(8),    32'h020,      1, 0);
        vt[10] = mk(0, 0, 0, 1, 32'h10,       32'h010,      nop,      32'h024,      0, 0);
        vt[11] = mk(0, 0, 1, 0, 32'h0,        32'h014,      nop,      32'h010,      0, 0);
        vt[12] = mk(0, 0, 0, 0, 32'h0,        32'h018,      mw(5),    32'h014,      1, 0);
        vt[13] = mk(0, 0, 0, 0, 32'h0,        32'h01C,      mw(6),    32'h018,      1, 0);
        vt[14] = mk(0, 0, 0, 1, 32'h3FC,      32'h3FC,      nop,      32'h01C,      0, 0);
        vt[15] = mk(0, 0, 0, 0, 32'h0,        32'h400,      mw(255),  32'h3FC,      1, 0);
        vt[16] = mk(0, 0, 0, 0, 32'h0,        32'h404,      nop,      32'h400,      1, 1);
        vt[17] = mk(0, 1, 1, 0, 32'h0,        32'h404,      nop,      32'h404,      0, 0);
        vt[18] = mk(0, 0, 0, 0, 32'h0,        32'h408,      nop,      32'h404,      1, 1);
        vt[19] = mk(1, 1, 0, 1, 32'h80,       32'h000,      nop,      32'h000,      0, 0);
        vt[20] = mk(0, 0, 0, 0, 32'h0,        32'h004,      mw(0),    32'h000,      1, 0);
        vt[21] = mk(0, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, nop,    32'h004,      0, 0);
        vt[22] = mk(0, 0, 0, 0, 32'h0,        32'h000,      nop,      32'hFFFF_FFFC, 1, 1);
        vt[23] = mk(0, 0, 0, 0, 32'h0,        32'h004,      mw(0),    32'h000,      1, 0);

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].rst, vt[i].stall, vt[i].flush, vt[i].rv, vt[i].rp);
            tick();
            chk_state(i, vt[i].e_pc, vt[i].e_instr, vt[i].e_ifpc,
                      vt[i].rst ? 32'h0 : vt[i].e_ifpc + 32'd4, vt[i].e_v, vt[i].e_f);
        end

        // Free run from reset against a simple PC model.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        pc_m = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("run_imem_addr", 100 + i, 32'(bus.imem_addr), 32'(i + 1));
            chk("run_if_id_pc", 100 + i, bus.if_id_pc, pc_m);
            chk("run_if_id_instr", 100 + i, bus.if_id_instr, mw(i));
            pc_m = pc_m + 32'd4;
        end

`ifdef FETCH_PERF_CNT_EN
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("fetch_count_reset", 200, fetch_count, 32'd0);
        chk("bubble_count_reset", 200, bubble_count, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        chk("fetch_count", 201, fetch_count, 32'd5);
        chk("bubble_count", 201, bubble_count, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
